controle_load_store: RTL and testbench
======================================

Name: controle_load_store

Overview:
FSM controller that sequences the shared add/sub ALU datapath (register-register operation or base+offset address generation) for a minimal ADD/SUB/LD/ST instruction stream. Accepts one instruction at a time via valid/ready. Drives register-file read/write addresses, datapath selects (op_mem, add_sub, offset) and a request/acknowledge memory port with timeout. Sits between instruction issue and the operation/memory datapath.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEM without mem_ack before abort (>=1)
CNT_W, $clog2(MEM_TIMEOUT+1), width of timeout counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction presented
instr_ready  out  1  controller can accept instruction
instr_op  in  2  00 ADD, 01 SUB, 10 LD, 11 ST
instr_rd  in  5  destination register
instr_rs1  in  5  source 1 / base register
instr_rs2  in  5  source 2 / store-data register
instr_offset  in  5  address offset (LD/ST)
rf_ra_addr  out  5  read port A address (datapath dinA)
rf_rb_addr  out  5  read port B address (datapath dinB)
rf_we  out  1  register write enable
rf_wr_addr  out  5  write address
rf_wr_sel  out  1  0 = ALU result, 1 = memory read data
op_mem  out  1  datapath select: 0 = dinA op dinB, 1 = dinB + offset
add_sub  out  1  0 = add, 1 = subtract
offset  out  5  offset to datapath
mem_req  out  1  memory request, address = ALU out, write data = dinA
mem_we  out  1  1 = store, 0 = load; valid while mem_req=1
mem_ack  in  1  memory completion
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle timeout pulse

Behaviour:
- Reset: state IDLE; all outputs 0 except instr_ready; latched fields and counter 0. Reset mid-operation aborts immediately: mem_req drops next cycle, no rf_we, no done/err.
- instr_ready = (state==IDLE) && !rst. Handshake = instr_valid && instr_ready; fields latched on that edge. Outputs derive only from latched fields, stable EXEC through WB.
- Address mapping: ADD/SUB: ra=rs1, rb=rs2. LD/ST: rb=rs1 (base), ra=rs2 (store data). wr_addr=rd.
- States:
  IDLE: wait for handshake -> EXEC.
  EXEC (1 cycle): op_mem=(op[1]), add_sub=(op==SUB), offset driven; ADD/SUB -> WB; LD/ST -> MEM, counter cleared.
  MEM: mem_req=1, mem_we=(op==ST), datapath selects held. mem_ack -> WB. Else counter+1; when counter == MEM_TIMEOUT-1 with no ack -> ERR. Ack on the timeout cycle wins (-> WB).
  WB (1 cycle): done=1; rf_we=1 unless op==ST or rd==0; rf_wr_sel=(op==LD). -> IDLE.
  ERR (1 cycle): err=1, mem_req=0, no write. -> IDLE.
- rf_we, mem_req, done and err are 0 in every state not listed for them. op_mem/add_sub return to 0 in IDLE; addresses hold last latched value.
- Latency: ADD/SUB handshake at cycle 0, WB at cycle 2, ready at cycle 3. LD/ST: WB one cycle after the ack cycle.
- mem_ack outside MEM ignored. instr_valid while busy ignored (not latched).

Test Plan:
1. ADD rd=3 rs1=1 rs2=2 accepted c0 -> c1 op_mem=0 add_sub=0 ra=1 rb=2; c2 rf_we=1 wr_addr=3 wr_sel=0 done=1; c3 instr_ready=1.
2. SUB rd=0 rs1=7 rs2=9 -> c1 add_sub=1; c2 done=1, rf_we=0.
3. LD rd=5 rs1=4 offset=8, mem_ack 3rd MEM cycle -> op_mem=1 rb=4 offset=8, mem_req=1 mem_we=0 3 cycles, then rf_we=1 wr_sel=1 wr_addr=5 done=1.
4. ST rs1=6 rs2=10 offset=31, mem_ack first MEM cycle -> mem_req 1 cycle mem_we=1 ra=10 rb=6; WB done=1 rf_we=0; back-to-back ADD with valid held is accepted the cycle after WB.
5. MEM_TIMEOUT=4, LD no ack -> mem_req 4 cycles, err=1 one cycle, no rf_we/done; repeat with ack on 4th MEM cycle -> normal WB, err=0.
6. rst during MEM (valid held high) -> next cycle mem_req=0 busy=0 all outputs 0; no handshake while rst=1; accepted the first cycle after release.

Source files
------------

// File: rtl/controle_load_store.sv
// Sequencing controller for a shared add/sub ALU datapath running a minimal
// ADD/SUB/LD/ST stream; one instruction in flight, memory port with timeout.
//
// state | meaning
// IDLE  | waiting for instruction handshake
// EXEC  | datapath selects driven, one cycle
// MEM   | memory request outstanding, counting toward timeout
// WB    | register write-back and done pulse, one cycle
// ERR   | memory timeout, err pulse, no write, one cycle
module controle_load_store #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [1:0] instr_op,
  input  logic [4:0] instr_rd,
  input  logic [4:0] instr_rs1,
  input  logic [4:0] instr_rs2,
  input  logic [4:0] instr_offset,
  output logic [4:0] rf_ra_addr,
  output logic [4:0] rf_rb_addr,
  output logic       rf_we,
  output logic [4:0] rf_wr_addr,
  output logic       rf_wr_sel,
  output logic       op_mem,
  output logic       add_sub,
  output logic [4:0] offset,
  output logic       mem_req,
  output logic       mem_we,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;
  localparam logic [1:0] OP_ST  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q;
  logic [1:0]       op_q;
  logic [4:0]       rd_q;
  logic [4:0]       ra_q;
  logic [4:0]       rb_q;
  logic [4:0]       offset_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rf_we_q;
  logic             rf_wr_sel_q;
  logic             op_mem_q;
  logic             add_sub_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic             done_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      offset_q    <= '0;
      cnt_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_wr_sel_q <= 1'b0;
      op_mem_q    <= 1'b0;
      add_sub_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // pulse-type outputs are asserted only by the branch entering their state
      rf_we_q     <= 1'b0;
      rf_wr_sel_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            state_q   <= S_EXEC;
            op_q      <= instr_op;
            rd_q      <= instr_rd;
            ra_q      <= instr_op[1] ? instr_rs2 : instr_rs1;
            rb_q      <= instr_op[1] ? instr_rs1 : instr_rs2;
            offset_q  <= instr_offset;
            op_mem_q  <= instr_op[1];
            add_sub_q <= (instr_op == OP_SUB);
          end
        end
        S_EXEC: begin
          if (op_q[1]) begin
            state_q   <= S_MEM;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            mem_we_q  <= (op_q == OP_ST);
          end else begin
            state_q     <= S_WB;
            done_q      <= 1'b1;
            rf_we_q     <= (rd_q != 5'd0);
            rf_wr_sel_q <= 1'b0;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            state_q     <= S_WB;
            done_q      <= 1'b1;
            rf_we_q     <= (op_q != OP_ST) && (rd_q != 5'd0);
            rf_wr_sel_q <= (op_q == OP_LD);
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            mem_req_q <= 1'b1;
            mem_we_q  <= (op_q == OP_ST);
          end
        end
        S_WB, S_ERR: begin
          state_q   <= S_IDLE;
          op_mem_q  <= 1'b0;
          add_sub_q <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          op_mem_q  <= 1'b0;
          add_sub_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign busy        = (state_q != S_IDLE);
  assign rf_ra_addr  = ra_q;
  assign rf_rb_addr  = rb_q;
  assign rf_wr_addr  = rd_q;
  assign rf_we       = rf_we_q;
  assign rf_wr_sel   = rf_wr_sel_q;
  assign op_mem      = op_mem_q;
  assign add_sub     = add_sub_q;
  assign offset      = offset_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_controle_load_store.sv
// Self-checking bench for controle_load_store: directed scenarios plus random
// instruction stream against a per-instruction cycle model.
module tb_controle_load_store;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [1:0] instr_op = 2'b00;
  logic [4:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0, instr_offset = '0;
  logic [4:0] rf_ra_addr, rf_rb_addr, rf_wr_addr, offset;
  logic       rf_we, rf_wr_sel, op_mem, add_sub, mem_req, mem_we;
  logic       mem_ack = 1'b0;
  logic       busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  controle_load_store #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_offset(instr_offset),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_we(rf_we),
    .rf_wr_addr(rf_wr_addr), .rf_wr_sel(rf_wr_sel), .op_mem(op_mem),
    .add_sub(add_sub), .offset(offset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // observed vector: busy ready we wsel mreq mwe done err opm asub | off ra rb wa
  logic [29:0] obs;
  assign obs = {busy, instr_ready, rf_we, rf_wr_sel, mem_req, mem_we, done, err,
                op_mem, add_sub, offset, rf_ra_addr, rf_rb_addr, rf_wr_addr};

  function automatic logic [29:0] mk(input logic b, r, we, ws, mq, mw, d, er, om, as,
                                     input logic [4:0] of, a, bb, wa);
    return {b, r, we, ws, mq, mw, d, er, om, as, of, a, bb, wa};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    instr_valid  = 1'($urandom_range(0, 1));
    instr_op     = 2'($urandom);
    instr_rd     = 5'($urandom);
    instr_rs1    = 5'($urandom);
    instr_rs2    = 5'($urandom);
    instr_offset = 5'($urandom);
  endtask

  // Issue one instruction from IDLE and follow it cycle by cycle back to IDLE.
  // ack_at: MEM cycle (1-based) carrying mem_ack, 0 = never.
  task automatic run_instr(input string nm, input logic [1:0] op,
                           input logic [4:0] rd, rs1, rs2, off, input int ack_at);
    logic [4:0]  ra_e, rb_e;
    logic [29:0] e;
    int          n_mem;
    bit          ok;
    bit          is_st, is_ld, is_sub, we_e;
    is_st  = (op == 2'b11);
    is_ld  = (op == 2'b10);
    is_sub = (op == 2'b01);
    ra_e   = op[1] ? rs2 : rs1;
    rb_e   = op[1] ? rs1 : rs2;
    we_e   = !is_st && (rd != 5'd0);
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_offset = off;
    instr_valid = 1'b1;
    mem_ack = 1'($urandom_range(0, 1));
    n_tests++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b want 1", nm, instr_ready);
    end
    tick();
    scramble();
    mem_ack = 1'($urandom_range(0, 1));
    e = mk(1, 0, 0, 0, 0, 0, 0, 0, op[1], is_sub, off, ra_e, rb_e, rd);
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s exec: got %h want %h", nm, obs, e);
    end
    ok = 1'b1;
    if (op[1]) begin
      ok    = (ack_at >= 1) && (ack_at <= TO);
      n_mem = ok ? ack_at : TO;
      for (int k = 1; k <= n_mem; k++) begin
        tick();
        scramble();
        mem_ack = (k == ack_at);
        e = mk(1, 0, 0, 0, 1, is_st, 0, 0, 1, 0, off, ra_e, rb_e, rd);
        n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL %s mem%0d: got %h want %h", nm, k, obs, e);
        end
      end
    end
    tick();
    scramble();
    mem_ack = 1'($urandom_range(0, 1));
    if (ok) e = mk(1, 0, we_e, is_ld, 0, 0, 1, 0, op[1], is_sub, off, ra_e, rb_e, rd);
    else    e = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, off, ra_e, rb_e, rd);
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s %s: got %h want %h", nm, ok ? "wb" : "err", obs, e);
    end
    tick();
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    e = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, off, ra_e, rb_e, rd);
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s idle: got %h want %h", nm, obs, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_valid = 1'b1;
    tick();
    tick();
    n_tests++;
    if (obs !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", obs, 30'd0);
    end
    rst = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_tests++;
    if (obs !== mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs,
               mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_add();
    run_instr("add", 2'b00, 5'd3, 5'd1, 5'd2, 5'd0, 0);
  endtask

  task automatic test_sub_rd0();
    run_instr("sub_rd0", 2'b01, 5'd0, 5'd7, 5'd9, 5'd4, 0);
  endtask

  task automatic test_load();
    run_instr("ld", 2'b10, 5'd5, 5'd4, 5'd0, 5'd8, 3);
  endtask

  task automatic test_back_to_back();
    run_instr("st", 2'b11, 5'd12, 5'd6, 5'd10, 5'd31, 1);
    run_instr("b2b_add", 2'b00, 5'd17, 5'd21, 5'd22, 5'd0, 0);
  endtask

  task automatic test_timeout();
    run_instr("ld_timeout", 2'b10, 5'd9, 5'd2, 5'd3, 5'd5, 0);
    run_instr("ld_ack_last", 2'b10, 5'd9, 5'd2, 5'd3, 5'd5, TO);
    run_instr("st_timeout", 2'b11, 5'd1, 5'd8, 5'd11, 5'd16, 0);
  endtask

  task automatic test_reset_mid_mem();
    logic [29:0] e;
    instr_op = 2'b10; instr_rd = 5'd5; instr_rs1 = 5'd4; instr_rs2 = 5'd0;
    instr_offset = 5'd8; instr_valid = 1'b1; mem_ack = 1'b0;
    tick();
    tick();
    tick();
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: mem_req got %b want 1", mem_req);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (obs !== 30'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got %h want %h", obs, 30'd0);
    end
    tick();
    n_tests++;
    if (obs !== 30'd0) begin
      n_fail++;
      $display("FAIL rst_mid_hold: got %h want %h", obs, 30'd0);
    end
    instr_op = 2'b00; instr_rd = 5'd3; instr_rs1 = 5'd1; instr_rs2 = 5'd2;
    instr_offset = 5'd0;
    rst = 1'b0;
    tick();
    instr_valid = 1'b0;
    e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 5'd3);
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rst_accept_exec: got %h want %h", obs, e);
    end
    tick();
    e = mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 5'd3);
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rst_accept_wb: got %h want %h", obs, e);
    end
    tick();
    e = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 5'd3);
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL rst_accept_idle: got %h want %h", obs, e);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_instr("rand", 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), int'($urandom_range(0, TO + 1)));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_rd0();
    test_load();
    test_back_to_back();
    test_timeout();
    test_reset_mid_mem();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
